// File: rtl/i2c_lcd_pkg.sv
// ============================================================================
// Module      : i2c_lcd_pkg
// Description : Shared types and constants for the I2C LCD writer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package i2c_lcd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_SHIFT = 3'd2,
    ST_ACK   = 3'd3,
    ST_STOP  = 3'd4
  } state_t;

  localparam logic [7:0] CTRL_CMD     = 8'h00;
  localparam logic [7:0] CTRL_DATA    = 8'h40;
  localparam logic [6:0] DEFAULT_ADDR = 7'h3E;

  // Quarter-period divider, floored, never below one clock.
  function automatic int qdiv_calc(input int clk_hz, input int i2c_hz);
    int d;
    d = clk_hz / (4 * i2c_hz);
    return (d < 1) ? 1 : d;
  endfunction

  function automatic logic [7:0] ctrl_byte(input logic rs);
    return rs ? CTRL_DATA : CTRL_CMD;
  endfunction

endpackage

`default_nettype wire

// File: rtl/i2c_qtick.sv
// ============================================================================
// Module      : i2c_qtick
// Description : Quarter-bit tick generator; one tick every QDIV clocks,
//               counter restarts to zero on restart.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module i2c_qtick #(
  parameter int QDIV = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic tick
);

  localparam int            CW   = (QDIV > 1) ? $clog2(QDIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(QDIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (restart || cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = (cnt == LAST);

endmodule

`default_nettype wire

// File: rtl/i2c_lcd_writer.sv
// ============================================================================
// Module      : i2c_lcd_writer
// Description : Sends {addr,W}, control byte, data byte to an I2C LCD per
//               request. Optional macro I2C_LCD_ACK_CHECK_EN aborts on NACK.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module i2c_lcd_writer
  import i2c_lcd_pkg::*;
#(
  parameter int         CLK_HZ   = 6750000,
  parameter int         I2C_HZ   = 100000,
  parameter logic [6:0] DEV_ADDR = DEFAULT_ADDR
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       in_rs,
  input  logic [7:0] in_data,
  output logic       scl_oe,
  output logic       sda_oe,
  input  logic       sda_i,
  output logic       busy,
  output logic       done,
  output logic       nack
);

  localparam int QDIV = qdiv_calc(CLK_HZ, I2C_HZ);

  state_t     state;
  logic [1:0] q;
  logic [2:0] bit_cnt;
  logic [1:0] byte_idx;
  logic [7:0] shreg;
  logic       rs_r;
  logic [7:0] data_r;
  logic       tick;
  logic       accept;
  logic       ack_fail;
  logic [7:0] next_byte;

  assign in_ready  = (state == ST_IDLE);
  assign busy      = (state != ST_IDLE);
  assign accept    = in_valid && in_ready;
  assign next_byte = (byte_idx == 2'd0) ? ctrl_byte(rs_r) : data_r;

`ifdef I2C_LCD_ACK_CHECK_EN
  logic ack_bit;
  assign ack_fail = ack_bit;
`else
  logic sda_unused;
  assign sda_unused = sda_i;
  assign ack_fail   = 1'b0;
`endif

  i2c_qtick #(
    .QDIV(QDIV)
  ) u_qtick (
    .clk    (clk),
    .rst    (rst),
    .restart(accept),
    .tick   (tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      q        <= 2'd0;
      bit_cnt  <= 3'd0;
      byte_idx <= 2'd0;
      shreg    <= 8'h00;
      rs_r     <= 1'b0;
      data_r   <= 8'h00;
      scl_oe   <= 1'b0;
      sda_oe   <= 1'b0;
      done     <= 1'b0;
      nack     <= 1'b0;
`ifdef I2C_LCD_ACK_CHECK_EN
      ack_bit  <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          scl_oe <= 1'b0;
          sda_oe <= 1'b0;
          if (accept) begin
            state    <= ST_START;
            q        <= 2'd0;
            rs_r     <= in_rs;
            data_r   <= in_data;
            shreg    <= {DEV_ADDR, 1'b0};
            bit_cnt  <= 3'd7;
            byte_idx <= 2'd0;
            nack     <= 1'b0;
          end
        end

        // SDA falls while SCL is high, then SCL is pulled low.
        ST_START: begin
          if (tick) begin
            q <= q + 2'd1;
            case (q)
              2'd0: sda_oe <= 1'b1;
              2'd2: scl_oe <= 1'b1;
              2'd3: begin
                state  <= ST_SHIFT;
                sda_oe <= ~shreg[7];
              end
              default: ;
            endcase
          end
        end

        ST_SHIFT: begin
          if (tick) begin
            q <= q + 2'd1;
            case (q)
              2'd0: scl_oe <= 1'b0;
              2'd2: scl_oe <= 1'b1;
              2'd3: begin
                if (bit_cnt == 3'd0) begin
                  state  <= ST_ACK;
                  sda_oe <= 1'b0;
                end else begin
                  bit_cnt <= bit_cnt - 3'd1;
                  shreg   <= {shreg[6:0], 1'b0};
                  sda_oe  <= ~shreg[6];
                end
              end
              default: ;
            endcase
          end
        end

        ST_ACK: begin
          if (tick) begin
            q <= q + 2'd1;
            case (q)
              2'd0: scl_oe <= 1'b0;
              2'd1: begin
`ifdef I2C_LCD_ACK_CHECK_EN
                ack_bit <= sda_i;
`endif
              end
              2'd2: scl_oe <= 1'b1;
              2'd3: begin
                if (byte_idx == 2'd2 || ack_fail) begin
                  state  <= ST_STOP;
                  sda_oe <= 1'b1;
`ifdef I2C_LCD_ACK_CHECK_EN
                  if (ack_fail) nack <= 1'b1;
`endif
                end else begin
                  state    <= ST_SHIFT;
                  shreg    <= next_byte;
                  sda_oe   <= ~next_byte[7];
                  bit_cnt  <= 3'd7;
                  byte_idx <= byte_idx + 2'd1;
                end
              end
              default: ;
            endcase
          end
        end

        // SCL rises with SDA low, then SDA rises while SCL is high.
        ST_STOP: begin
          if (tick) begin
            q <= q + 2'd1;
            case (q)
              2'd0: scl_oe <= 1'b0;
              2'd1: sda_oe <= 1'b0;
              2'd3: begin
                state <= ST_IDLE;
                done  <= 1'b1;
              end
              default: ;
            endcase
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_i2c_lcd_writer.sv
// ============================================================================
// Module      : tb_i2c_lcd_writer
// Description : Directed self-checking bench with I2C bus monitor/slave model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_i2c_lcd_writer;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic       in_rs;
  logic [7:0] in_data;
  logic       scl_oe;
  logic       sda_oe;
  logic       sda_i;
  logic       busy;
  logic       done;
  logic       nack;

  logic slave_low = 1'b0;
  assign sda_i = ~(sda_oe | slave_low);

  always #5 clk = ~clk;

  i2c_lcd_writer #(
    .CLK_HZ  (6750000),
    .I2C_HZ  (100000),
    .DEV_ADDR(7'h3E)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_rs   (in_rs),
    .in_data (in_data),
    .scl_oe  (scl_oe),
    .sda_oe  (sda_oe),
    .sda_i   (sda_i),
    .busy    (busy),
    .done    (done),
    .nack    (nack)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Bus monitor and ACKing slave, evaluated on the falling clock edge.
  logic       prev_scl = 1'b1;
  logic       prev_sda = 1'b1;
  int         bitn = 0;
  logic [7:0] sh = 8'h00;
  int         start_cnt = 0;
  int         stop_cnt = 0;
  int         txn_bytes = 0;
  bit         nack_addr = 1'b0;
  logic [7:0] bq[$];

  always @(negedge clk) begin
    logic scl_l;
    logic sda_l;
    scl_l = ~scl_oe;
    sda_l = ~(sda_oe | slave_low);
    if (rst) begin
      bitn      = 0;
      slave_low = 1'b0;
    end else if (scl_l && prev_scl && prev_sda && !sda_l) begin
      start_cnt++;
      bitn      = 0;
      txn_bytes = 0;
    end else if (scl_l && prev_scl && !prev_sda && sda_l) begin
      stop_cnt++;
    end else if (scl_l && !prev_scl) begin
      if (bitn < 8) begin
        sh = {sh[6:0], sda_l};
        if (bitn == 7) begin
          bq.push_back(sh);
          txn_bytes++;
        end
      end
      bitn = (bitn == 8) ? 0 : bitn + 1;
    end else if (!scl_l && prev_scl) begin
      slave_low = (bitn == 8) && !(nack_addr && txn_bytes == 1);
    end
    prev_scl = scl_l;
    prev_sda = sda_l;
  end

  int tests = 0;
  int fails = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run_txn(input logic rs, input logic [7:0] d, output int lat);
    int acc;
    @(negedge clk);
    in_valid = 1'b1;
    in_rs    = rs;
    in_data  = d;
    acc      = cyc + 1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = -1;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (done) begin
        lat = cyc - acc;
        break;
      end
    end
  endtask

  int lat;
  int lat2;
  int s0;
  int p0;
  int acc2;

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    in_rs    = 1'b0;
    in_data  = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_scl_oe", scl_oe, 0);
    chk("rst_sda_oe", sda_oe, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_nack", nack, 0);
    rst = 1'b0;
    @(negedge clk);

    // Command write
    bq.delete();
    s0 = start_cnt;
    p0 = stop_cnt;
    run_txn(1'b0, 8'h38, lat);
    chk("cmd_latency", lat, 1856);
    chk("cmd_nbytes", bq.size(), 3);
    chk("cmd_byte0", bq[0], 8'h7C);
    chk("cmd_byte1", bq[1], 8'h00);
    chk("cmd_byte2", bq[2], 8'h38);
    chk("cmd_nack", nack, 0);
    chk("cmd_starts", start_cnt - s0, 1);
    chk("cmd_stops", stop_cnt - p0, 1);
    chk("cmd_idle_bus", {scl_oe, sda_oe, busy}, 0);
    @(negedge clk);
    chk("cmd_done_pulse", done, 0);

    // Data write
    bq.delete();
    s0 = start_cnt;
    p0 = stop_cnt;
    run_txn(1'b1, 8'h41, lat);
    chk("dat_latency", lat, 1856);
    chk("dat_nbytes", bq.size(), 3);
    chk("dat_byte0", bq[0], 8'h7C);
    chk("dat_byte1", bq[1], 8'h40);
    chk("dat_byte2", bq[2], 8'h41);
    chk("dat_starts", start_cnt - s0, 1);
    chk("dat_stops", stop_cnt - p0, 1);

    // Address NACK
    bq.delete();
    p0 = stop_cnt;
    nack_addr = 1'b1;
    run_txn(1'b0, 8'h38, lat);
    nack_addr = 1'b0;
    chk("nak_stops", stop_cnt - p0, 1);
    chk("nak_byte0", bq[0], 8'h7C);
`ifdef I2C_LCD_ACK_CHECK_EN
    chk("nak_latency", lat, 704);
    chk("nak_nbytes", bq.size(), 1);
    chk("nak_nack", nack, 1);
`else
    chk("nak_latency", lat, 1856);
    chk("nak_nbytes", bq.size(), 3);
    chk("nak_nack", nack, 0);
`endif

    // Accept clears nack
    bq.delete();
    @(negedge clk);
    in_valid = 1'b1;
    in_rs    = 1'b0;
    in_data  = 8'h01;
    @(posedge clk);
    #1 in_valid = 1'b0;
    chk("clr_nack", nack, 0);
    chk("clr_busy", busy, 1);
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (done) break;
    end
    chk("clr_done_seen", done, 1);
    chk("clr_byte2", bq[2], 8'h01);

    // Back-to-back with in_valid held
    bq.delete();
    s0 = start_cnt;
    run_txn(1'b0, 8'h38, lat);
    @(negedge clk);
    in_valid = 1'b1;
    in_rs    = 1'b0;
    in_data  = 8'h38;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (done) break;
    end
    chk("b2b_done1", done, 1);
    chk("b2b_ready_at_done", in_ready, 1);
    chk("b2b_idle_bus", {scl_oe, sda_oe}, 0);
    in_rs   = 1'b1;
    in_data = 8'h48;
    acc2    = cyc + 1;
    @(posedge clk);
    #1;
    chk("b2b_accept_next", busy, 1);
    chk("b2b_ready_low", in_ready, 0);
    in_valid = 1'b0;
    lat2 = -1;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (done) begin
        lat2 = cyc - acc2;
        break;
      end
    end
    chk("b2b_latency2", lat2, 1856);
    chk("b2b_nbytes", bq.size(), 9);
    chk("b2b_byte6", bq[6], 8'h7C);
    chk("b2b_byte7", bq[7], 8'h40);
    chk("b2b_byte8", bq[8], 8'h48);
    chk("b2b_starts", start_cnt - s0, 3);

    // Reset mid-SHIFT
    @(negedge clk);
    in_valid = 1'b1;
    in_rs    = 1'b0;
    in_data  = 8'h38;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (330) @(negedge clk);
    chk("mid_busy", busy, 1);
    chk("mid_scl_low", scl_oe, 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_scl_oe", scl_oe, 0);
    chk("arst_sda_oe", sda_oe, 0);
    chk("arst_busy", busy, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("arst_in_ready", in_ready, 1);
    chk("arst_done", done, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire

// File: doc/i2c_lcd_writer.md
I2C_LCD_WRITER -- requirements
Module: i2c_lcd_writer

Interface
REQ-001 Parameter CLK_HZ, default 6750000: frequency of clk, in Hz.
REQ-002 Parameter I2C_HZ, default 100000: target SCL frequency, in Hz.
REQ-003 Parameter DEV_ADDR, default 7'h3E: 7-bit I2C address of the LCD.
REQ-004 Port clk, input, 1 bit: sole clock; all logic on its rising edge.
REQ-005 Port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 Port in_valid, input, 1 bit: a request is present on in_rs/in_data.
REQ-007 Port in_ready, output, 1 bit: block can accept a request.
REQ-008 Port in_rs, input, 1 bit: 0 = command (control byte 8'h00), 1 = data (control byte 8'h40).
REQ-009 Port in_data, input, 8 bits: command or data byte.
REQ-010 Port scl_oe, output, 1 bit: 1 = drive SCL low, 0 = release SCL.
REQ-011 Port sda_oe, output, 1 bit: 1 = drive SDA low, 0 = release SDA.
REQ-012 Port sda_i, input, 1 bit: sampled SDA line level.
REQ-013 Port busy, output, 1 bit: a transaction is in progress.
REQ-014 Port done, output, 1 bit: one-cycle pulse at the end of each transaction.
REQ-015 Port nack, output, 1 bit: sticky flag; a NACK was detected.

Function
REQ-016 Quarter-tick divider: QDIV = CLK_HZ/(4*I2C_HZ), integer floor, minimum 1; one tick every QDIV clk cycles; counter restarts on accept.
REQ-017 Handshake: accept when in_valid && in_ready; in_ready = 1 only in IDLE; in_rs/in_data are registered on accept.
REQ-018 States: IDLE -> START -> SHIFT -> ACK -> (SHIFT of next byte | STOP) -> IDLE.
REQ-019 Bytes are sent in this order, MSB first: {DEV_ADDR,1'b0}, control byte, data byte.
REQ-020 START is 4 quarters: SDA low at quarter 1 while SCL is released, then SCL low at quarter 3.
REQ-021 Each bit is 4 quarters: q0 SCL low and SDA set up; q1 SCL released; q2 SCL held released; q3 SCL low.
REQ-022 ACK bit: SDA released; sda_i sampled at the q1->q2 tick.
REQ-023 STOP is 4 quarters: SDA low with SCL low, then SCL released, then SDA released; done pulses on the clk after the final tick.
REQ-024 Total transaction length = 116 quarters = 116*QDIV clk cycles from accept to done.
REQ-025 in_valid held high through done gives back-to-back transactions; the next accept occurs on the cycle after done.
REQ-026 In IDLE, scl_oe = sda_oe = 0 and busy = 0.
REQ-027 nack is cleared only by an accept or by reset.

Reset
REQ-028 rst asserted in any state: state goes to IDLE immediately and asynchronously; scl_oe = 0, sda_oe = 0, busy = 0, done = 0, nack = 0, in_ready = 1 after release.
REQ-029 A mid-transaction reset does not emit STOP; the bus is simply released.

Configuration
REQ-030 Macro I2C_LCD_ACK_CHECK_EN defined: a 1 sampled in any ACK slot sets nack, the remaining bytes are skipped, and the block goes directly to STOP (done still pulses).
REQ-031 Macro I2C_LCD_ACK_CHECK_EN undefined: the ACK slot is clocked but ignored, nack is tied to 0, and every transaction is 116 quarters long.

Structure
REQ-032 Shared package i2c_lcd_pkg holds: the state enum, the control-byte constants CTRL_CMD = 8'h00 and CTRL_DATA = 8'h40, and the default address 7'h3E.
REQ-033 One sub-module, i2c_qtick: the quarter-tick divider with a restart input.

Verification
REQ-034 Scenario, reset: rst pulse mid-SHIFT -> scl_oe = sda_oe = 0 the same cycle; in_ready = 1 after release.
REQ-035 Scenario, command: rs = 0, data = 8'h38, slave ACKs -> bus bytes 7C, 00, 38; done exactly 1856 clk after accept (QDIV = 16); nack = 0.
REQ-036 Scenario, data: rs = 1, data = 8'h41 -> bytes 7C, 40, 41; START/STOP edges ordered per REQ-020 and REQ-023.
REQ-037 Scenario, NACK on address with I2C_LCD_ACK_CHECK_EN -> nack = 1, STOP follows the first ACK slot, done pulses; the next accept clears nack.
REQ-038 Scenario, same NACK without the macro -> all 3 bytes sent, nack = 0.
REQ-039 Scenario, back-to-back: in_valid held for 2 requests -> second accept on the cycle after the first done; bus idle between STOP and the next START.
